ann_aer_spike_encoder: RTL and testbench

- Transmitter end of the layer-1 AER link. It holds the ANN-stage feature vector, converts each feature to a time-to-first-spike value in Q1.7, and emits one AER event per spiking feature.
- Events use a 4-phase req/ack handshake toward the SNN engine. After the last feature it raises done.
- Sits between the ANN front-end, which writes the features, and the SNN engine's dense-1 input (i_enc_aer_*, i_enc_done, o_enc_aer_ack).

---
 rtl/snn_pkg.sv | 17 +
 rtl/feature_ram.sv | 20 ++
 rtl/ann_aer_spike_encoder.sv | 148 ++++++++++++++
 tb/tb_ann_aer_spike_encoder.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the layer-1 AER spike link.
package snn_pkg;
  localparam int AER_TIME_W = 8;
  localparam int AER_ADDR_W = 10;
  localparam logic signed [AER_TIME_W-1:0] T_MIN_Q17_DEF = 8'sd0;
  localparam logic signed [AER_TIME_W-1:0] T_MAX_Q17_DEF = 8'sd20;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CALC    = 3'd2,
    ST_REQ     = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } enc_state_e;
endpackage

// File: rtl/feature_ram.sv
// Feature vector storage: single write port, synchronous read, contents never reset.
module feature_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 160,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/ann_aer_spike_encoder.sv
// Converts stored ANN features to time-to-first-spike values and sends one
// AER event per positive feature over a 4-phase req/ack handshake.
module ann_aer_spike_encoder
  import snn_pkg::*;
#(
  parameter int FEAT_W      = 16,
  parameter int FEAT_SHIFT  = 8,
  parameter int TIME_W      = AER_TIME_W,
  parameter int ADDR_W      = AER_ADDR_W,
  parameter int VEC_LEN     = 160,
  parameter logic signed [TIME_W-1:0] T_MIN_Q17 = T_MIN_Q17_DEF,
  parameter logic signed [TIME_W-1:0] T_MAX_Q17 = T_MAX_Q17_DEF,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                     local_clk,
  input  logic                     rst_n,
  input  logic                     i_feat_wr_en,
  input  logic [ADDR_W-1:0]        i_feat_wr_addr,
  input  logic signed [FEAT_W-1:0] i_feat_wr_data,
  input  logic                     i_start,
  output logic                     o_aer_req,
  output logic [TIME_W-1:0]        o_aer_time,
  output logic [ADDR_W-1:0]        o_aer_addr,
  input  logic                     i_aer_ack,
  output logic                     o_done,
  output logic                     o_busy,
  output logic                     o_error,
  output logic [ADDR_W-1:0]        o_spike_count
);
  localparam int RAM_AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int TMO_W  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LIM  = TMO_W'(ACK_TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VEC_LEN - 1);
  localparam logic signed [TIME_W-1:0] SPAN_T = T_MAX_Q17 - T_MIN_Q17;
  localparam logic signed [FEAT_W-1:0] SPAN_F = {{(FEAT_W-TIME_W){SPAN_T[TIME_W-1]}}, SPAN_T};

  enc_state_e               state;
  logic [ADDR_W-1:0]        idx;
  logic [TMO_W-1:0]         tmo;
  logic signed [FEAT_W-1:0] feat;
  logic                     wr_ok;

  // Clamp the shifted feature into the usable spike-time window width.
  function automatic logic signed [TIME_W-1:0] sat_span(input logic signed [FEAT_W-1:0] v);
    if (v[FEAT_W-1]) return '0;
    if (v > SPAN_F)  return SPAN_T;
    return v[TIME_W-1:0];
  endfunction

  assign wr_ok = i_feat_wr_en && (state == ST_IDLE || state == ST_DONE) &&
                 (i_feat_wr_addr <= LAST_IDX);

  feature_ram #(
    .DATA_W (FEAT_W),
    .DEPTH  (VEC_LEN),
    .AW     (RAM_AW)
  ) u_ram (
    .clk     (local_clk),
    .wr_en   (wr_ok),
    .wr_addr (i_feat_wr_addr[RAM_AW-1:0]),
    .wr_data (i_feat_wr_data),
    .rd_addr (idx[RAM_AW-1:0]),
    .rd_data (feat)
  );

  assign o_busy = (state != ST_IDLE) && (state != ST_DONE);

  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      idx           <= '0;
      tmo           <= '0;
      o_aer_req     <= 1'b0;
      o_aer_time    <= '0;
      o_aer_addr    <= '0;
      o_done        <= 1'b0;
      o_error       <= 1'b0;
      o_spike_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            idx           <= '0;
            o_spike_count <= '0;
            state         <= ST_FETCH;
          end
        end
        ST_FETCH: state <= ST_CALC;
        ST_CALC: begin
          if (feat[FEAT_W-1] || feat == '0) begin
            if (idx == LAST_IDX) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= ST_FETCH;
            end
          end else begin
            o_aer_time <= T_MAX_Q17 - sat_span(feat >>> FEAT_SHIFT);
            o_aer_addr <= idx;
            o_aer_req  <= 1'b1;
            tmo        <= '0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_aer_ack) begin
            o_aer_req     <= 1'b0;
            o_spike_count <= o_spike_count + ADDR_W'(1);
            tmo           <= '0;
            state         <= ST_RELEASE;
          end else if (tmo == TMO_LIM) begin
            o_error   <= 1'b1;
            o_aer_req <= 1'b0;
            state     <= ST_ERROR;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        ST_RELEASE: begin
          if (!i_aer_ack) begin
            tmo <= '0;
            if (idx == LAST_IDX) begin
              o_done <= 1'b1;
              state  <= ST_DONE;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= ST_FETCH;
            end
          end else if (tmo == TMO_LIM) begin
            o_error <= 1'b1;
            state   <= ST_ERROR;
          end else begin
            tmo <= tmo + TMO_W'(1);
          end
        end
        ST_DONE: begin
          if (!i_start) begin
            o_done <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_ERROR: state <= ST_ERROR;
        default:  state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ann_aer_spike_encoder.sv
// Directed bench for ann_aer_spike_encoder with a 4-entry feature vector.
module tb_ann_aer_spike_encoder;
  localparam int VL  = 4;
  localparam int TMO = 1023;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [9:0]  wr_addr = '0;
  logic signed [15:0] wr_data = '0;
  logic        start = 1'b0;
  logic        req;
  logic [7:0]  tm;
  logic [9:0]  addr;
  logic        ack = 1'b0;
  logic        done, busy, err;
  logic [9:0]  cnt;

  int checks = 0;
  int failures = 0;

  logic [9:0] ev_addr [16];
  logic [7:0] ev_time [16];
  int n_ev, n_unstable;
  bit run_to;

  ann_aer_spike_encoder #(.VEC_LEN(VL), .ACK_TIMEOUT(TMO)) dut (
    .local_clk      (clk),
    .rst_n          (rst_n),
    .i_feat_wr_en   (wr_en),
    .i_feat_wr_addr (wr_addr),
    .i_feat_wr_data (wr_data),
    .i_start        (start),
    .o_aer_req      (req),
    .o_aer_time     (tm),
    .o_aer_addr     (addr),
    .i_aer_ack      (ack),
    .o_done         (done),
    .o_busy         (busy),
    .o_error        (err),
    .o_spike_count  (cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_feat(input logic [9:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load4(input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
    wr_feat(10'd0, d0); wr_feat(10'd1, d1); wr_feat(10'd2, d2); wr_feat(10'd3, d3);
  endtask

  // Acts as the SNN engine: acks each request ack_delay cycles after it is seen.
  task automatic run_events(input int ack_delay);
    n_ev = 0; n_unstable = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      tick();
      if (req && !ack && n_ev < 16) begin
        ev_addr[n_ev] = addr;
        ev_time[n_ev] = tm;
        repeat (ack_delay) begin
          tick();
          if (!req || addr !== ev_addr[n_ev] || tm !== ev_time[n_ev]) n_unstable++;
        end
        ack = 1'b1;
        for (int w = 0; w < 20 && req; w++) tick();
        ack = 1'b0;
        n_ev++;
      end
    end
    run_to = !done;
  endtask

  task automatic end_run();
    start = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({req, tm, addr, done, busy, err, cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got req=%0b t=%0d a=%0d done=%0b busy=%0b err=%0b cnt=%0d exp all 0",
               req, tm, addr, done, busy, err, cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    load4(16'h1400, 16'h0500, 16'h0000, 16'hFF00);
    start = 1'b1;
    tick(); tick();
    checks++;
    if (req !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL t1_early_req got req=%0b busy=%0b exp req=0 busy=1", req, busy);
    end
    tick();
    checks++;
    if (req !== 1'b1 || addr !== 10'd0 || tm !== 8'd0) begin
      failures++; $display("FAIL t1_latency got req=%0b a=%0d t=%0d exp req=1 a=0 t=0", req, addr, tm);
    end
    run_events(2);
    checks++;
    if (run_to || n_ev != 2) begin
      failures++; $display("FAIL t1_events got n=%0d timeout=%0b exp n=2", n_ev, run_to);
    end else begin
      checks++;
      if (ev_addr[0] !== 10'd0 || ev_time[0] !== 8'd0 || ev_addr[1] !== 10'd1 || ev_time[1] !== 8'd15) begin
        failures++;
        $display("FAIL t1_payload got (%0d,%0d)(%0d,%0d) exp (0,0)(1,15)",
                 ev_addr[0], ev_time[0], ev_addr[1], ev_time[1]);
      end
    end
    checks++;
    if (cnt !== 10'd2) begin
      failures++; $display("FAIL t1_count got=%0d exp=2", cnt);
    end
    repeat (3) tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL t1_done_hold got done=%0b busy=%0b exp done=1 busy=0", done, busy);
    end
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL t1_done_clear got done=%0b busy=%0b exp 0 0", done, busy);
    end
    tick();
  endtask

  task automatic test_saturation();
    load4(16'h7FFF, 16'h0100, 16'h0001, 16'h8000);
    start = 1'b1;
    run_events(1);
    checks++;
    if (run_to || n_ev != 3) begin
      failures++; $display("FAIL t2_events got n=%0d timeout=%0b exp n=3", n_ev, run_to);
    end else begin
      checks++;
      if (ev_time[0] !== 8'd0 || ev_time[1] !== 8'd19 || ev_time[2] !== 8'd20 || ev_addr[2] !== 10'd2) begin
        failures++;
        $display("FAIL t2_times got t0=%0d t1=%0d t2=%0d a2=%0d exp 0 19 20 2",
                 ev_time[0], ev_time[1], ev_time[2], ev_addr[2]);
      end
    end
    checks++;
    if (cnt !== 10'd3) begin
      failures++; $display("FAIL t2_count got=%0d exp=3", cnt);
    end
    end_run();
  endtask

  task automatic test_handshake();
    int req_hi;
    load4(16'h0500, 16'h0000, 16'h0000, 16'h0000);
    start = 1'b1;
    run_events(3);
    checks++;
    if (run_to || n_ev != 1 || n_unstable != 0 || cnt !== 10'd1 || ev_time[0] !== 8'd15) begin
      failures++;
      $display("FAIL t3_slow_ack got n=%0d unstable=%0d cnt=%0d t=%0d exp 1 0 1 15",
               n_ev, n_unstable, cnt, ev_time[0]);
    end
    end_run();
    start = 1'b1;
    run_events(0);
    checks++;
    if (run_to || n_ev != 1 || cnt !== 10'd1) begin
      failures++; $display("FAIL t3_zero_delay got n=%0d cnt=%0d exp 1 1", n_ev, cnt);
    end
    end_run();
    // ack already high before the request appears
    start = 1'b1; ack = 1'b1;
    req_hi = 0;
    repeat (8) begin
      tick();
      if (req) req_hi++;
    end
    checks++;
    if (req_hi != 1 || cnt !== 10'd1 || done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL t3_early_ack got req_cycles=%0d cnt=%0d done=%0b busy=%0b exp 1 1 0 1",
               req_hi, cnt, done, busy);
    end
    ack = 1'b0;
    for (int w = 0; w < 20 && !done; w++) tick();
    checks++;
    if (done !== 1'b1 || cnt !== 10'd1) begin
      failures++; $display("FAIL t3_early_ack_done got done=%0b cnt=%0d exp 1 1", done, cnt);
    end
    end_run();
  endtask

  task automatic test_timeout();
    int waited;
    start = 1'b1;
    for (int w = 0; w < 10 && !req; w++) tick();
    waited = 0;
    while (!err && waited < TMO + 10) begin
      tick();
      waited++;
    end
    checks++;
    if (err !== 1'b1 || waited < TMO || waited > TMO + 2) begin
      failures++; $display("FAIL t4_timeout got err=%0b cycles=%0d exp err=1 cycles~%0d", err, waited, TMO + 1);
    end
    checks++;
    if (req !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL t4_req_drop got req=%0b busy=%0b exp 0 1", req, busy);
    end
    start = 1'b0; ack = 1'b1;
    repeat (10) tick();
    ack = 1'b0;
    repeat (5) tick();
    checks++;
    if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL t4_sticky got err=%0b done=%0b busy=%0b exp 1 0 1", err, done, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req, tm, addr, done, busy, err, cnt} !== '0) begin
      failures++;
      $display("FAIL t4_reset_clear got req=%0b t=%0d a=%0d done=%0b busy=%0b err=%0b cnt=%0d exp all 0",
               req, tm, addr, done, busy, err, cnt);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    load4(16'h0100, 16'h0500, 16'h0000, 16'h0000);
    start = 1'b1;
    for (int w = 0; w < 10 && !req; w++) tick();
    ack = 1'b1;
    for (int w = 0; w < 10 && req; w++) tick();
    ack = 1'b0;
    for (int w = 0; w < 10 && !req; w++) tick();
    checks++;
    if (req !== 1'b1 || addr !== 10'd1) begin
      failures++; $display("FAIL t5_second_req got req=%0b a=%0d exp 1 1", req, addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (req !== 1'b0 || done !== 1'b0 || cnt !== 10'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL t5_abort got req=%0b done=%0b cnt=%0d busy=%0b exp 0 0 0 0", req, done, cnt, busy);
    end
    start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    run_events(1);
    checks++;
    if (run_to || n_ev != 2 || ev_addr[0] !== 10'd0 || ev_time[0] !== 8'd19 || ev_time[1] !== 8'd15) begin
      failures++;
      $display("FAIL t5_rerun got n=%0d a0=%0d t0=%0d t1=%0d exp 2 0 19 15", n_ev, ev_addr[0], ev_time[0], ev_time[1]);
    end
    end_run();
  endtask

  task automatic test_write_guard();
    load4(16'h0500, 16'h0000, 16'h0000, 16'h0000);
    wr_feat(10'd4, 16'h1400);
    start = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = 10'd0; wr_data = 16'h1400;
    tick();
    wr_en = 1'b0;
    run_events(1);
    checks++;
    if (run_to || n_ev != 1 || ev_time[0] !== 8'd15) begin
      failures++; $display("FAIL t6_busy_write got n=%0d t=%0d exp 1 15", n_ev, ev_time[0]);
    end
    end_run();
    start = 1'b1;
    run_events(1);
    checks++;
    if (run_to || n_ev != 1 || ev_time[0] !== 8'd15 || ev_addr[0] !== 10'd0) begin
      failures++; $display("FAIL t6_next_run got n=%0d a=%0d t=%0d exp 1 0 15", n_ev, ev_addr[0], ev_time[0]);
    end
    end_run();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_handshake();
    test_timeout();
    test_reset_mid();
    test_write_guard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
